// File: rtl/name_display_pkg.sv
// Shared definitions for the name display: blank code, letter indices and
// sequencer state/output types used by both the sequencer and the decoder.
package name_display_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Letter indices of the displayed word, in display order.
    localparam logic [3:0] LTR_G = 4'd0;
    localparam logic [3:0] LTR_I = 4'd1;
    localparam logic [3:0] LTR_L = 4'd2;
    localparam logic [3:0] LTR_B = 4'd3;
    localparam logic [3:0] LTR_E = 4'd4;
    localparam logic [3:0] LTR_R = 4'd5;
    localparam logic [3:0] LTR_T = 4'd6;
    localparam logic [3:0] LTR_O = 4'd7;
    localparam int         WORD_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [3:0] digit;
        logic       valid;
        logic       done;
    } disp_t;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/name_sequencer_if.sv
// Control/display bundle between the board controls, the sequencer and the decoder.
interface name_sequencer_if;
    import name_display_pkg::*;

    logic       en;
    logic       hold;
    logic [3:0] digit;
    logic       digit_valid;
    logic       word_done;

    modport master (
        output en, hold,
        input  digit, digit_valid, word_done
    );

    modport slave (
        input  en, hold,
        output digit, digit_valid, word_done
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV tick generator with synchronous clear and run gate.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);
    import name_display_pkg::*;

    localparam int CW = cnt_w(DIV);
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run)
            cnt <= (cnt == TOP) ? '0 : cnt + CW'(1);
    end

    // A frozen count must not keep re-firing, so tick is gated by run.
    assign tick = run && (cnt == TOP);

endmodule

// File: rtl/name_sequencer.sv
// Steps the decoder's letter index through the word with blank gaps and an
// end-of-word pause; all outputs are registered from the next state.
module name_sequencer
    import name_display_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int NUM_LETTERS = 8,
    parameter int SHOW_TICKS  = 2,
    parameter int GAP_TICKS   = 1,
    parameter int PAUSE_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    name_sequencer_if.slave  bus
);

    localparam int MAXT = (SHOW_TICKS > GAP_TICKS)
                        ? ((SHOW_TICKS > PAUSE_TICKS) ? SHOW_TICKS : PAUSE_TICKS)
                        : ((GAP_TICKS > PAUSE_TICKS) ? GAP_TICKS : PAUSE_TICKS);
    localparam int TW = cnt_w(MAXT);
    localparam logic [3:0] LAST = 4'(NUM_LETTERS - 1);

    seq_state_t    state, state_n;
    logic [3:0]    idx, idx_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          done_n;
    logic          tick;
    logic          last;
    logic          gap_exit;
    int            span;
    disp_t         out_q;

    tick_prescaler #(.DIV(CLK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE) || !bus.en),
        .run  (bus.en && !bus.hold),
        .tick (tick)
    );

    always_comb begin
        span = 1;
        unique case (state)
            SHOW:    span = SHOW_TICKS;
            GAP:     span = GAP_TICKS;
            PAUSE:   span = PAUSE_TICKS;
            default: span = 1;
        endcase
    end

    assign last = tick && (int'(tcnt) == span - 1);

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        tcnt_n   = tcnt;
        done_n   = 1'b0;
        gap_exit = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
            idx_n   = '0;
            tcnt_n  = '0;
        end else if (!bus.hold) begin
            if (tick)
                tcnt_n = tcnt + TW'(1);
            unique case (state)
                IDLE: begin
                    state_n = SHOW;
                    idx_n   = '0;
                    tcnt_n  = '0;
                end
                SHOW: if (last) begin
                    tcnt_n = '0;
                    if (GAP_TICKS == 0)
                        gap_exit = 1'b1;
                    else
                        state_n = GAP;
                end
                GAP: if (last) begin
                    tcnt_n   = '0;
                    gap_exit = 1'b1;
                end
                PAUSE: if (last) begin
                    state_n = SHOW;
                    idx_n   = '0;
                    tcnt_n  = '0;
                end
                default: state_n = IDLE;
            endcase
            // End of a letter's gap: advance, or wrap and flag the finished word.
            if (gap_exit) begin
                if (idx >= LAST) begin
                    idx_n   = '0;
                    done_n  = 1'b1;
                    state_n = (PAUSE_TICKS == 0) ? SHOW : PAUSE;
                end else begin
                    idx_n   = idx + 4'd1;
                    state_n = SHOW;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            tcnt  <= tcnt_n;
        end
    end

    // Outputs follow the registered state; under hold state_n/idx_n are
    // unchanged, so the display freezes while done_n is forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '{digit: BLANK_CODE, valid: 1'b0, done: 1'b0};
        end else begin
            out_q.digit <= (state_n == SHOW) ? idx_n : BLANK_CODE;
            out_q.valid <= (state_n == SHOW);
            out_q.done  <= done_n;
        end
    end

    assign bus.digit       = out_q.digit;
    assign bus.digit_valid = out_q.valid;
    assign bus.word_done   = out_q.done;

endmodule

// File: tb/tb_name_sequencer.sv
// Directed bench: expected per-cycle outputs are queued from the timing rules
// and compared one cycle at a time against the default and a corner instance.
module tb_name_sequencer;
    import name_display_pkg::*;

    typedef struct packed {
        logic [3:0] d;
        logic       v;
        logic       w;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   sel   = 1'b0;
    exp_t q[$];

    name_sequencer_if m();
    name_sequencer_if c();

    name_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    name_sequencer #(
        .CLK_DIV(4), .NUM_LETTERS(1), .SHOW_TICKS(2), .GAP_TICKS(0), .PAUSE_TICKS(0)
    ) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input exp_t e);
        exp_t o;
        if (sel)
            o = {c.digit, c.digit_valid, c.word_done};
        else
            o = {m.digit, m.digit_valid, m.word_done};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got d=%h v=%b w=%b want d=%h v=%b w=%b",
                   tag, o.d, o.v, o.w, e.d, e.v, e.w);
        end
    endtask

    task automatic push_n(input logic [3:0] d, input logic v, input logic w, input int n);
        for (int i = 0; i < n; i++)
            q.push_back({d, v, w});
    endtask

    // One letter at default timing: 8 shown cycles then 4 blank gap cycles.
    task automatic letter(input logic [3:0] l);
        push_n(l, 1'b1, 1'b0, 8);
        push_n(BLANK_CODE, 1'b0, 1'b0, 4);
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            chk(tag, q.pop_front());
        end
    endtask

    initial begin
        rst    = 1'b1;
        m.en   = 1'b0;
        m.hold = 1'b0;
        c.en   = 1'b0;
        c.hold = 1'b0;
        #1;
        chk("reset", {BLANK_CODE, 1'b0, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_rel", {BLANK_CODE, 1'b0, 1'b0});

        // Idle with en low.
        push_n(BLANK_CODE, 1'b0, 1'b0, 20);
        drain("idle");

        // Full word, pause, then the next word up to mid-SHOW of idx 3.
        m.en = 1'b1;
        for (int l = 0; l < WORD_LEN; l++)
            letter(4'(l));
        push_n(BLANK_CODE, 1'b0, 1'b1, 1);
        push_n(BLANK_CODE, 1'b0, 1'b0, 11);
        letter(LTR_G);
        letter(LTR_I);
        letter(LTR_L);
        push_n(LTR_B, 1'b1, 1'b0, 3);
        drain("word");

        // Hold for 10 cycles stretches idx 3's SHOW by exactly 10 cycles.
        m.hold = 1'b1;
        push_n(LTR_B, 1'b1, 1'b0, 10);
        drain("hold");
        m.hold = 1'b0;
        push_n(LTR_B, 1'b1, 1'b0, 5);
        push_n(BLANK_CODE, 1'b0, 1'b0, 4);
        letter(LTR_E);
        push_n(LTR_R, 1'b1, 1'b0, 8);
        push_n(BLANK_CODE, 1'b0, 1'b0, 2);
        drain("post_hold");

        // Disable in the gap after idx 5, then restart from idx 0.
        m.en = 1'b0;
        push_n(BLANK_CODE, 1'b0, 1'b0, 5);
        drain("disable");
        m.en = 1'b1;
        letter(LTR_G);
        push_n(LTR_I, 1'b1, 1'b0, 3);
        drain("reenable");

        // Asynchronous reset between edges, mid-SHOW of idx 1.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {BLANK_CODE, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        chk("in_rst", {BLANK_CODE, 1'b0, 1'b0});
        rst = 1'b0;
        letter(LTR_G);
        push_n(LTR_I, 1'b1, 1'b0, 2);
        drain("after_rst");

        // Corner instance: one letter, no gap, no pause.
        sel  = 1'b1;
        c.en = 1'b1;
        push_n(4'd0, 1'b1, 1'b0, 8);
        for (int k = 0; k < 4; k++) begin
            push_n(4'd0, 1'b1, 1'b1, 1);
            push_n(4'd0, 1'b1, 1'b0, 7);
        end
        drain("corner");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
